lcd_fifo_rd_arbiter: RTL

//  Shares the single 16-bit read port of the SDRAM-to-LCD read FIFO between two burst requesters.

---
 rtl/lcd_fifo_rd_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lcd_fifo_rd_arbiter.sv
// lcd_fifo_rd_arbiter
// Shares the 16-bit read port of the SDRAM-to-LCD read FIFO between two
// burst requesters (0 = LCD pixel combiner, 1 = capture/debug reader).
// A fixed BURST_LEN-word burst is granted only when the FIFO already holds
// a full burst, so a granted burst never stalls on an empty FIFO.
// Round-robin between the two requesters when both ask in the same cycle.
//
// Optional feature: define LCD_FIFO_RD_ARB_TIMEOUT_EN to enable a starvation
// counter that sets the sticky err_timeout flag after TIMEOUT idle cycles
// with a request pending but too few words in the FIFO.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a request with fifo_usedw >= BURST_LEN
// S_READ  | fifo_rd asserted, one word per cycle, BURST_LEN cycles
// S_DRAIN | last word arriving on fifo_q; done pulse; grant released

module lcd_fifo_rd_arbiter #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 6,
  parameter int LVL_W     = 10,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  input  logic [LVL_W-1:0]  fifo_usedw,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_q,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld0,
  output logic              rd_vld1,
  output logic              err_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [LVL_W-1:0] LVL_BURST = LVL_W'(BURST_LEN);
  localparam logic [7:0]       BEAT_LAST = 8'(BURST_LEN - 1);

  logic [1:0] state;
  logic [7:0] beat;
  logic       last_gnt;   // 1: requester 1 was served last
  logic       any_req;
  logic       level_ok;
  logic       grant_now;
  logic       pick1;

  assign rd_data   = fifo_q;
  assign any_req   = req0 | req1;
  assign level_ok  = (fifo_usedw >= LVL_BURST);
  assign grant_now = (state == S_IDLE) && any_req && level_ok;
  // req1 wins when alone, or when both ask and requester 0 was served last
  assign pick1     = req1 & (~req0 | ~last_gnt);

  // Burst sequencer: grant, read strobes, delayed valid strobes and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      beat     <= 8'd0;
      last_gnt <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      fifo_rd  <= 1'b0;
      rd_vld0  <= 1'b0;
      rd_vld1  <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
    end else begin
      // fifo_q is valid one cycle after fifo_rd, so valid is fifo_rd delayed
      rd_vld0 <= fifo_rd & gnt0;
      rd_vld1 <= fifo_rd & gnt1;
      done0   <= fifo_rd & gnt0 & (beat == BEAT_LAST);
      done1   <= fifo_rd & gnt1 & (beat == BEAT_LAST);
      case (state)
        S_IDLE: begin
          if (grant_now) begin
            state   <= S_READ;
            gnt0    <= ~pick1;
            gnt1    <= pick1;
            fifo_rd <= 1'b1;
            beat    <= 8'd0;
          end
        end
        S_READ: begin
          if (beat == BEAT_LAST) begin
            beat    <= 8'd0;
            fifo_rd <= 1'b0;
            state   <= S_DRAIN;
          end else begin
            beat <= beat + 8'd1;
          end
        end
        S_DRAIN: begin
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          last_gnt <= gnt1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LCD_FIFO_RD_ARB_TIMEOUT_EN
  localparam int              TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  logic [TO_W-1:0] to_cnt;

  // Starvation counter: counts idle cycles where a request waits on FIFO level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (to_cnt == TO_MAX) err_timeout <= 1'b1;
      if (grant_now) begin
        to_cnt <= '0;
      end else if ((state == S_IDLE) && any_req && !level_ok && (to_cnt != TO_MAX)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule
